pc_sequencer: RTL and testbench

Program-counter sequencer for the single-cycle CSE141L core. It owns the 10-bit PC register and runs the IDLE/RUN/DONE program lifecycle around a Start/Done handshake. It drives the 4-bit index into the branch-target lookup table (`LUT_pc`) and chooses each cycle between PC+1, a held PC (stall) and the absolute LUT target. It also keeps cycle and instruction counters and a watchdog that ends runaway programs.

---
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, runs the IDLE/RUN/DONE lifecycle,
// selects PC+1 / hold / LUT target, and keeps cycle, instruction and watchdog state.
module pc_sequencer #(
  parameter int PC_W = 10,
  parameter int LUT_AW = 4,
  parameter int CNT_W = 16,
  parameter int unsigned MAX_CYCLES = 32'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              Taken,
  input  logic              JumpEn,
  input  logic [LUT_AW-1:0] BranchImm,
  input  logic              Halt,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutTarget,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic              Timeout,
  output logic [CNT_W-1:0]  CycleCount,
  output logic [CNT_W-1:0]  InstCount
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);

  state_t            state_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [CNT_W-1:0]  cycle_reg;
  logic [CNT_W-1:0]  inst_reg;
  logic              timeout_reg;
  logic              running_reg;
  logic              done_reg;

  logic [CNT_W-1:0]  cycle_next;
  logic [CNT_W-1:0]  inst_next;
  logic              redirect;

  // Target table is indexed straight from the immediate so the target is usable the same cycle.
  assign LutAddr = BranchImm;

  assign cycle_next = (cycle_reg == CNT_MAX) ? cycle_reg : cycle_reg + CNT_W'(1);
  assign inst_next  = (inst_reg == CNT_MAX) ? inst_reg : inst_reg + CNT_W'(1);
  assign redirect   = JumpEn | (BranchEn & Taken);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      cycle_reg   <= '0;
      inst_reg    <= '0;
      timeout_reg <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (Start) begin
            state_reg   <= RUN;
            pc_reg      <= StartAddr;
            cycle_reg   <= '0;
            inst_reg    <= '0;
            timeout_reg <= 1'b0;
            running_reg <= 1'b1;
            done_reg    <= 1'b0;
          end
        end
        RUN: begin
          // Watchdog wins over every instruction event; nothing retires on that edge.
          if (cycle_reg == WD_LIMIT) begin
            state_reg   <= DONE;
            timeout_reg <= 1'b1;
            running_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            cycle_reg <= cycle_next;
            if (!Stall) begin
              inst_reg <= inst_next;
              if (Halt) begin
                state_reg   <= DONE;
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
              end else if (redirect) begin
                pc_reg <= LutTarget;
              end else begin
                pc_reg <= pc_reg + PC_W'(1);
              end
            end
          end
        end
        default: begin
          state_reg   <= IDLE;
          running_reg <= 1'b0;
          done_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_reg;
  assign Running    = running_reg;
  assign Done       = done_reg;
  assign Timeout    = timeout_reg;
  assign CycleCount = cycle_reg;
  assign InstCount  = inst_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus pushes expected state,
// a monitor pops and compares after each clock edge. Second instance has an 8-cycle watchdog.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic       stall = 1'b0;
  logic       branch_en = 1'b0;
  logic       taken = 1'b0;
  logic       jump_en = 1'b0;
  logic [3:0] branch_imm = '0;
  logic       halt = 1'b0;

  logic [3:0]  lut_addr0, lut_addr1;
  logic [9:0]  lut_target0, lut_target1;
  logic [9:0]  pc0, pc1;
  logic        running0, running1, done0, done1, timeout0, timeout1;
  logic [15:0] cyc0, cyc1, inst0, inst1;

  logic [9:0] lut_mem [16];

  assign lut_target0 = lut_mem[lut_addr0];
  assign lut_target1 = lut_mem[lut_addr1];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
    .Stall(stall), .BranchEn(branch_en), .Taken(taken), .JumpEn(jump_en),
    .BranchImm(branch_imm), .Halt(halt), .LutAddr(lut_addr0), .LutTarget(lut_target0),
    .PC(pc0), .Running(running0), .Done(done0), .Timeout(timeout0),
    .CycleCount(cyc0), .InstCount(inst0)
  );

  pc_sequencer #(.MAX_CYCLES(8)) dut_wd (
    .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
    .Stall(stall), .BranchEn(branch_en), .Taken(taken), .JumpEn(jump_en),
    .BranchImm(branch_imm), .Halt(halt), .LutAddr(lut_addr1), .LutTarget(lut_target1),
    .PC(pc1), .Running(running1), .Done(done1), .Timeout(timeout1),
    .CycleCount(cyc1), .InstCount(inst1)
  );

  typedef struct {
    string       name;
    int          which;
    logic [9:0]  pc;
    logic        running;
    logic        done;
    logic        timeout;
    logic [15:0] cyc;
    logic [15:0] inst;
    logic [3:0]  lut_addr;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input string field, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: after every rising edge, compare the entry pushed for that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.which == 0) begin
          chk(e.name, "pc", int'(pc0), int'(e.pc));
          chk(e.name, "running", int'(running0), int'(e.running));
          chk(e.name, "done", int'(done0), int'(e.done));
          chk(e.name, "timeout", int'(timeout0), int'(e.timeout));
          chk(e.name, "cycles", int'(cyc0), int'(e.cyc));
          chk(e.name, "insts", int'(inst0), int'(e.inst));
          chk(e.name, "lut_addr", int'(lut_addr0), int'(e.lut_addr));
        end else begin
          chk(e.name, "pc", int'(pc1), int'(e.pc));
          chk(e.name, "running", int'(running1), int'(e.running));
          chk(e.name, "done", int'(done1), int'(e.done));
          chk(e.name, "timeout", int'(timeout1), int'(e.timeout));
          chk(e.name, "cycles", int'(cyc1), int'(e.cyc));
          chk(e.name, "insts", int'(inst1), int'(e.inst));
          chk(e.name, "lut_addr", int'(lut_addr1), int'(e.lut_addr));
        end
        $display("check %s dut=%0d pc=%0d run=%0d done=%0d to=%0d cyc=%0d inst=%0d",
                 e.name, e.which, e.pc, e.running, e.done, e.timeout, e.cyc, e.inst);
      end
    end
  end

  // Push the state expected after the next rising edge, then advance to the next falling edge.
  task automatic step(input string name, input int which, input int e_pc, input bit e_run,
                      input bit e_done, input bit e_to, input int e_cyc, input int e_inst);
    exp_t e;
    e.name = name; e.which = which; e.pc = 10'(e_pc); e.running = e_run;
    e.done = e_done; e.timeout = e_to; e.cyc = 16'(e_cyc); e.inst = 16'(e_inst);
    e.lut_addr = branch_imm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic clr();
    start = 0; stall = 0; branch_en = 0; taken = 0; jump_en = 0; halt = 0; branch_imm = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = 10'(100 + i);
    lut_mem[0] = 10'd15; lut_mem[3] = 10'd19; lut_mem[5] = 10'd7; lut_mem[6] = 10'd12;

    @(negedge clk); @(negedge clk);
    step("reset", 0, 0, 0, 0, 0, 0, 0);

    // Straight-line run from 0, halt at PC 5.
    reset = 0; start = 1; start_addr = 0;
    step("start0", 0, 0, 1, 0, 0, 0, 0);
    clr();
    for (int i = 1; i <= 5; i++) step("seq", 0, i, 1, 0, 0, i, i);
    halt = 1;
    step("halt5", 0, 5, 0, 1, 0, 6, 6);
    clr(); stall = 1; jump_en = 1;
    step("done_hold", 0, 5, 0, 1, 0, 6, 6);
    clr();

    // Branches and jumps.
    start = 1; start_addr = 4;
    step("start4", 0, 4, 1, 0, 0, 0, 0);
    clr(); branch_en = 1; taken = 1; branch_imm = 0;
    step("br_taken", 0, 15, 1, 0, 0, 1, 1);
    taken = 0; branch_imm = 3;
    step("br_not_taken", 0, 16, 1, 0, 0, 2, 2);
    branch_en = 0; jump_en = 1; branch_imm = 3;
    step("jump", 0, 19, 1, 0, 0, 3, 3);
    clr(); start = 1; start_addr = 40;
    step("start_in_run", 0, 20, 1, 0, 0, 4, 4);
    clr(); jump_en = 1; branch_imm = 5;
    step("jump7", 0, 7, 1, 0, 0, 5, 5);

    // Stall with halt pending, then release.
    clr(); stall = 1; halt = 1; jump_en = 1; branch_imm = 6;
    for (int i = 1; i <= 3; i++) step("stall", 0, 7, 1, 0, 0, 5 + i, 5);
    stall = 0; jump_en = 0;
    step("stall_release", 0, 7, 0, 1, 0, 9, 6);

    // Halt coinciding with a taken branch.
    clr(); start = 1; start_addr = 30;
    step("start30", 0, 30, 1, 0, 0, 0, 0);
    clr(); halt = 1; branch_en = 1; taken = 1; branch_imm = 0;
    step("halt_vs_branch", 0, 30, 0, 1, 0, 1, 1);

    // Wrap-around and restart.
    clr(); start = 1; start_addr = 1022;
    step("start1022", 0, 1022, 1, 0, 0, 0, 0);
    clr();
    step("wrap1", 0, 1023, 1, 0, 0, 1, 1);
    step("wrap2", 0, 0, 1, 0, 0, 2, 2);
    step("wrap3", 0, 1, 1, 0, 0, 3, 3);
    halt = 1;
    step("halt_wrap", 0, 1, 0, 1, 0, 4, 4);
    clr(); start = 1; start_addr = 40;
    step("restart40", 0, 40, 1, 0, 0, 0, 0);
    clr(); jump_en = 1; branch_imm = 6;
    step("jump12", 0, 12, 1, 0, 0, 1, 1);

    // Reset mid-run with a simultaneous Start.
    clr(); reset = 1; start = 1; start_addr = 40;
    step("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    reset = 0; start = 0;
    step("idle_after", 0, 0, 0, 0, 0, 0, 0);

    // Watchdog instance (MAX_CYCLES = 8).
    start = 1; start_addr = 100;
    step("wd_start", 1, 100, 1, 0, 0, 0, 0);
    clr();
    for (int i = 1; i <= 7; i++) step("wd_run", 1, 100 + i, 1, 0, 0, i, i);
    halt = 1;
    step("wd_fire", 1, 107, 0, 1, 1, 7, 7);
    clr();
    step("wd_hold", 1, 107, 0, 1, 1, 7, 7);
    start = 1; start_addr = 200;
    step("wd_restart", 1, 200, 1, 0, 0, 0, 0);
    clr();

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
